kmac_digest_fetch: RTL and testbench
====================================

# kmac_digest_fetch

TL-UL host engine that drains the Keccak state read window into a 32-bit stream. It sits directly downstream of the state read window: it issues single-word Get reads to the window's TL-UL device port and, when masking is enabled, reads both shares and XORs them. It then presents unmasked digest words on a valid/ready stream to the digest consumer (DMA or key sideload).

## Interface
- AddrW, 9: TL-UL byte-address width of the state window. Must match the window.
- EnMasking, 0: when 1, read share 0 and share 1 per word and output their XOR. When 0, read share 0 only.
- MaxWords, 50: words in one share (1600/32). Requests above this are clamped.
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  single-cycle fetch request; sampled only in IDLE
- num_words_i  in  6  words to fetch, latched on accepted start
- busy_o  out  1  high from the cycle after an accepted start until DONE exits
- done_o  out  1  one-cycle pulse at fetch end, normal or error
- err_o  out  1  sticky; set on d_error; cleared on the next accepted start
- tl_o  out  tl_h2d_t  host request channel: a_valid, a_opcode, a_address, a_size, a_mask, a_source, d_ready
- tl_i  in  tl_d2h_t  device response channel: a_ready, d_valid, d_data, d_error
- digest_valid_o  out  1  output word valid
- digest_ready_i  in  1  consumer accepts word
- digest_data_o  out  32  unmasked digest word
- digest_last_o  out  1  high with the final word of a fetch

## Operation
- FSM states and transitions:
  - IDLE → REQ0 on start_i.
  - REQ0 → RSP0 on a_ready.
  - RSP0 → REQ1 on d_valid when EnMasking=1; RSP0 → OUT on d_valid when EnMasking=0.
  - REQ1 → RSP1 on a_ready.
  - RSP1 → OUT on d_valid.
  - OUT → REQ0 on digest_ready_i when the word is not the last; OUT → DONE on digest_ready_i when it is the last.
  - DONE → IDLE unconditionally.
- Word counter w, 6 bits: reset to 0 on start; incremented on each OUT handshake.
- Latched count N = min(num_words_i, MaxWords).
- If N=0: go IDLE → DONE. No TL requests, no stream output, done_o still pulses.
- Addresses:
  - Share 0: byte address = w×4.
  - Share 1: byte address = 256 + w×4. The share select is address bit 8, i.e. word offset 64.
- Every request uses a_opcode=Get (4), a_size=2, a_mask=4'hF, a_source=0.
- At most one request is outstanding.
- a_valid is high only in REQ0/REQ1. While it is high, a_address and the other request fields are held stable until a_ready.
- d_ready is high only in RSP0/RSP1. d_valid seen in any other state is ignored.
- Data path:
  - RSP0 captures d_data into hold register s0.
  - RSP1 computes s0 XOR d_data and stores the result into s0.
  - In OUT, digest_data_o = s0.
- digest_last_o = (w == N-1), valid only in OUT.
- Errors: d_error with d_valid in RSP0/RSP1 sets err_o, discards the word, and goes to DONE. No further requests are issued and no further stream words are emitted.
- start_i outside IDLE is ignored.
- Reset mid-operation: the FSM returns to IDLE and all outputs drop the same cycle (asynchronous). No pending response is awaited after reset.

## Timing
- Reset values:
  - busy_o, done_o, err_o, digest_valid_o, digest_last_o = 0.
  - digest_data_o = 0.
  - tl_o.a_valid = 0, tl_o.d_ready = 0; all other tl_o fields = 0.
- Sequence from start_i high at cycle 0: a_valid rises at cycle 1.
- Unmasked word, with a_ready and digest_ready_i both high: REQ0 (1 cycle) + RSP0 (1 cycle with the window's 1-cycle rvalid) + OUT (1 cycle) = 3 cycles per word.
- Masked word: 5 cycles per word.
- done_o pulses in the cycle after the final OUT handshake.
- Stream rule: digest_valid_o must not drop and digest_data_o must not change until digest_ready_i is seen.

## Test plan
- Unmasked read: state share 0 word k = 32'hA5000000+k; start with N=4 → exactly 4 Gets to addresses 0, 4, 8, 12. Stream carries A5000000..A5000003, with last on the 4th word. done_o pulses once; 12 cycles start-to-last with ready tied high.
- Masked read: EnMasking=1, share0 = 32'hFFFF0000, share1 = 32'h0F0F0F0F for every word; N=2 → Gets at 0, 256, 4, 260. Output is F0F00F0F twice.
- Backpressure: digest_ready_i low for 5 cycles in OUT → valid, data and last stay stable; no new a_valid until the handshake.
- Error: force d_error on word 2 of N=5 → 2 words output, err_o=1, done_o pulses, no further a_valid. The next start clears err_o.
- Boundaries: N=0 → done_o at cycle 1, no TL traffic. N=63 → clamped to 50, last address 196. start_i while busy → ignored.
- Reset asserted during RSP0 → all outputs are 0 immediately. A later start performs a clean full fetch.

Source files
------------

// File: rtl/kmac_digest_fetch_if.sv
// Shared TL-UL host types and the fetch engine's bus interface:
// one TL-UL host port plus the outgoing digest word stream.
package kmac_digest_fetch_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [31:0] a_address;
        logic [1:0]  a_size;
        logic [3:0]  a_mask;
        logic [7:0]  a_source;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        a_ready;
        logic        d_valid;
        logic [31:0] d_data;
        logic        d_error;
    } tl_d2h_t;

    localparam logic [2:0] Get = 3'd4;

endpackage

interface kmac_digest_fetch_if;
    import kmac_digest_fetch_pkg::*;

    tl_h2d_t     tl_o;
    tl_d2h_t     tl_i;
    logic        digest_valid_o;
    logic        digest_ready_i;
    logic [31:0] digest_data_o;
    logic        digest_last_o;

    modport master (
        output tl_o,
        input  tl_i,
        output digest_valid_o,
        input  digest_ready_i,
        output digest_data_o,
        output digest_last_o
    );

    modport slave (
        input  tl_o,
        output tl_i,
        input  digest_valid_o,
        output digest_ready_i,
        input  digest_data_o,
        input  digest_last_o
    );

endinterface

// File: rtl/kmac_digest_fetch.sv
// TL-UL host engine: reads the Keccak state window word by word,
// unmasks the shares and streams the digest out.
module kmac_digest_fetch
    import kmac_digest_fetch_pkg::*;
#(
    parameter int AddrW     = 9,
    parameter bit EnMasking = 1'b0,
    parameter int MaxWords  = 50
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [5:0] num_words_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    kmac_digest_fetch_if.master bus
);

    typedef enum logic [2:0] {
        Idle, Req0, Rsp0, Req1, Rsp1, Out, Done
    } state_e;

    localparam logic [5:0] MaxW = 6'(MaxWords);

    state_e      state_q;
    logic [5:0]  w_q;
    logic [5:0]  n_q;
    logic [5:0]  n_clamp;
    logic [31:0] s0_q;
    logic        err_q;
    logic        is_req;
    logic        is_rsp;
    logic        is_out;
    logic        last;
    logic [AddrW-1:0] addr;
    tl_h2d_t     tl_h2d;

    assign n_clamp = (num_words_i > MaxW) ? MaxW : num_words_i;
    assign is_req  = (state_q == Req0) || (state_q == Req1);
    assign is_rsp  = (state_q == Rsp0) || (state_q == Rsp1);
    assign is_out  = (state_q == Out);
    assign last    = (w_q == n_q - 6'd1);

    // Address bit 8 selects share 1 (word offset 64).
    assign addr = AddrW'({state_q == Req1, w_q, 2'b00});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            w_q     <= '0;
            n_q     <= '0;
            s0_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                Idle: if (start_i) begin
                    w_q     <= '0;
                    n_q     <= n_clamp;
                    err_q   <= 1'b0;
                    state_q <= (n_clamp == '0) ? Done : Req0;
                end
                Req0: if (bus.tl_i.a_ready) state_q <= Rsp0;
                Rsp0: if (bus.tl_i.d_valid) begin
                    if (bus.tl_i.d_error) begin
                        err_q   <= 1'b1;
                        state_q <= Done;
                    end else begin
                        s0_q    <= bus.tl_i.d_data;
                        state_q <= EnMasking ? Req1 : Out;
                    end
                end
                Req1: if (bus.tl_i.a_ready) state_q <= Rsp1;
                Rsp1: if (bus.tl_i.d_valid) begin
                    if (bus.tl_i.d_error) begin
                        err_q   <= 1'b1;
                        state_q <= Done;
                    end else begin
                        s0_q    <= s0_q ^ bus.tl_i.d_data;
                        state_q <= Out;
                    end
                end
                Out: if (bus.digest_ready_i) begin
                    w_q     <= w_q + 6'd1;
                    state_q <= last ? Done : Req0;
                end
                Done:    state_q <= Idle;
                default: state_q <= Idle;
            endcase
        end
    end

    always_comb begin
        tl_h2d = '0;
        if (is_req) begin
            tl_h2d.a_valid   = 1'b1;
            tl_h2d.a_opcode  = Get;
            tl_h2d.a_address = 32'(addr);
            tl_h2d.a_size    = 2'd2;
            tl_h2d.a_mask    = 4'hF;
        end
        tl_h2d.d_ready = is_rsp;
    end

    assign bus.tl_o           = tl_h2d;
    assign bus.digest_valid_o = is_out;
    assign bus.digest_data_o  = is_out ? s0_q : '0;
    assign bus.digest_last_o  = is_out && last;

    assign busy_o = (state_q != Idle);
    assign done_o = (state_q == Done);
    assign err_o  = err_q;

endmodule

// File: tb/tb_kmac_digest_fetch.sv
// Bench for kmac_digest_fetch: one unmasked and one masked instance,
// each behind a modelled state window with a digest sink.
module tb_kmac_digest_fetch;
    import kmac_digest_fetch_pkg::*;

    typedef struct {
        int g; int n; int errw; int esh;
        int rm; int arnd; int pat; int dbl;
        int exp_words; int exp_reqs; int exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic       start [2];
    logic [5:0] num [2];
    logic       busy [2];
    logic       done [2];
    logic       err [2];

    logic [31:0] m0 [2][64];
    logic [31:0] m1 [2][64];
    logic        err_en [2];
    logic [8:0]  err_addr [2];
    int          rmode [2];
    logic        arand [2];
    logic        rdy_man [2];

    logic        ar [2];
    logic        dv [2];
    logic        de [2];
    logic        dr [2];
    logic [31:0] dd [2];

    tl_h2d_t     tlo [2];
    logic        dvo [2];
    logic        dlo [2];
    logic        drdy [2];
    logic [31:0] ddo [2];

    logic [8:0]  aq [2][4096];
    int          acy [2][4096];
    int          an [2];
    logic [31:0] dq [2][4096];
    logic        lq [2][4096];
    int          dn [2];
    int          done_cnt [2];
    int          done_cyc [2];
    int          last_cyc [2];

    logic        ph [2];
    logic        pl [2];
    logic        pa [2];
    logic [31:0] pd [2];
    logic [31:0] pad [2];

    logic [8:0]  ea [256];
    logic [31:0] ed [128];
    logic        el [128];

    kmac_digest_fetch_if bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : gi
        kmac_digest_fetch #(
            .EnMasking (g == 1)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .start_i     (start[g]),
            .num_words_i (num[g]),
            .busy_o      (busy[g]),
            .done_o      (done[g]),
            .err_o       (err[g]),
            .bus         (bus[g])
        );
        assign bus[g].tl_i = {ar[g], dv[g], dd[g], de[g]};
        assign bus[g].digest_ready_i =
            (rmode[g] == 2) ? rdy_man[g] : dr[g];
        assign tlo[g]  = bus[g].tl_o;
        assign dvo[g]  = bus[g].digest_valid_o;
        assign dlo[g]  = bus[g].digest_last_o;
        assign ddo[g]  = bus[g].digest_data_o;
        assign drdy[g] = bus[g].digest_ready_i;
    end

    function automatic logic [31:0] rd(int g, logic [8:0] a);
        return a[8] ? m1[g][a[7:2]] : m0[g][a[7:2]];
    endfunction

    // State window: one-cycle read latency, optional a_ready stalls.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                ar[g] <= 1'b0;
                dv[g] <= 1'b0;
                dd[g] <= '0;
                de[g] <= 1'b0;
                dr[g] <= 1'b0;
            end else begin
                ar[g] <= arand[g] ? 1'($urandom_range(0, 1)) : 1'b1;
                dr[g] <= (rmode[g] == 1) ?
                         1'($urandom_range(0, 1)) : 1'b1;
                if (dv[g] && tlo[g].d_ready) dv[g] <= 1'b0;
                if (tlo[g].a_valid && ar[g]) begin
                    dv[g] <= 1'b1;
                    dd[g] <= rd(g, tlo[g].a_address[8:0]);
                    de[g] <= err_en[g] &&
                             (tlo[g].a_address[8:0] == err_addr[g]);
                end
            end
        end
    end

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Observe the settled cycle, then advance to the next one.
    task automatic step();
        #1;
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                ph[g] = 1'b0;
                pa[g] = 1'b0;
            end else begin
                if (pa[g])
                    chk("a_hold",
                        64'({tlo[g].a_valid, tlo[g].a_address}),
                        64'({1'b1, pad[g]}));
                if (ph[g])
                    chk("d_hold", 64'({dvo[g], dlo[g], ddo[g]}),
                        64'({1'b1, pl[g], pd[g]}));
                if (tlo[g].a_valid)
                    chk("one_outstanding", 64'(dv[g]), 64'(0));
                if (tlo[g].a_valid && ar[g]) begin
                    chk("a_fields",
                        64'({tlo[g].a_opcode, tlo[g].a_size,
                             tlo[g].a_mask, tlo[g].a_source,
                             tlo[g].d_ready}),
                        64'({3'd4, 2'd2, 4'hF, 8'h00, 1'b0}));
                    if (an[g] < 4096) begin
                        aq[g][an[g]]  = tlo[g].a_address[8:0];
                        acy[g][an[g]] = cyc;
                    end
                    an[g]++;
                end
                if (dvo[g] && drdy[g]) begin
                    if (dn[g] < 4096) begin
                        dq[g][dn[g]] = ddo[g];
                        lq[g][dn[g]] = dlo[g];
                    end
                    dn[g]++;
                    if (dlo[g]) last_cyc[g] = cyc;
                end
                if (done[g]) begin
                    done_cnt[g]++;
                    done_cyc[g] = cyc;
                end
                ph[g]  = dvo[g] && !drdy[g];
                pd[g]  = ddo[g];
                pl[g]  = dlo[g];
                pa[g]  = tlo[g].a_valid && !ar[g];
                pad[g] = tlo[g].a_address;
            end
        end
        @(negedge clk);
    endtask

    task automatic fill(int g, int pat);
        for (int k = 0; k < 64; k++) begin
            m0[g][k] = (pat == 0) ? 32'hA500_0000 + 32'(k) :
                       (pat == 1) ? 32'hFFFF_0000 : $urandom;
            m1[g][k] = (pat == 1) ? 32'h0F0F_0F0F : $urandom;
        end
    endtask

    task automatic run(input vec_t v);
        int g, nc, na, nw, per, d0, ab, db, st, t;
        logic stop;
        g = v.g;
        fill(g, v.pat);
        err_en[g]   = (v.errw >= 0);
        err_addr[g] = 9'((v.esh != 0 ? 256 : 0) + v.errw * 4);
        rmode[g]    = v.rm;
        arand[g]    = (v.arnd != 0);
        // Reference: the Gets and words the window should see.
        nc = (v.n > 50) ? 50 : v.n;
        na = 0; nw = 0; stop = 1'b0;
        for (int k = 0; k < nc && !stop; k++) begin
            ea[na++] = 9'(k * 4);
            if (v.errw == k && v.esh == 0) stop = 1'b1;
            if (!stop && g == 1) begin
                ea[na++] = 9'(256 + k * 4);
                if (v.errw == k && v.esh == 1) stop = 1'b1;
            end
            if (!stop) begin
                ed[nw] = m0[g][k] ^ ((g == 1) ? m1[g][k] : 32'h0);
                el[nw] = (k == nc - 1);
                nw++;
            end
        end
        d0 = done_cnt[g]; ab = an[g]; db = dn[g];
        start[g] = 1'b1;
        num[g]   = 6'(v.n);
        st       = cyc;
        step();
        start[g] = 1'b0;
        chk("busy_after_start", 64'(busy[g]), 64'(1));
        chk("err_cleared", 64'(err[g]), 64'(0));
        if (v.dbl != 0) begin
            step();
            step();
            start[g] = 1'b1;
            num[g]   = 6'd1;
            step();
            start[g] = 1'b0;
        end
        t = 0;
        while (done_cnt[g] == d0 && t < 4000) begin
            step();
            t++;
        end
        chk("done_seen", 64'(done_cnt[g] - d0), 64'(1));
        repeat ((v.dbl != 0) ? 12 : 4) step();
        chk("done_once", 64'(done_cnt[g] - d0), 64'(1));
        chk("busy_end", 64'(busy[g]), 64'(0));
        chk("err_o", 64'(err[g]), 64'(stop));
        chk("n_reqs", 64'(an[g] - ab), 64'(na));
        chk("n_words", 64'(dn[g] - db), 64'(nw));
        if (v.exp_words >= 0) begin
            chk("tab_words", 64'(dn[g] - db), 64'(v.exp_words));
            chk("tab_reqs", 64'(an[g] - ab), 64'(v.exp_reqs));
            chk("tab_err", 64'(err[g]), 64'(v.exp_err));
        end
        for (int i = 0; i < na; i++)
            chk("addr", 64'(aq[g][ab + i]), 64'(ea[i]));
        for (int i = 0; i < nw; i++) begin
            chk("data", 64'(dq[g][db + i]), 64'(ed[i]));
            chk("last", 64'(lq[g][db + i]), 64'(el[i]));
        end
        if (v.rm == 0 && v.arnd == 0 && v.errw < 0 && v.dbl == 0) begin
            per = (g == 1) ? 5 : 3;
            chk("done_cyc", 64'(done_cyc[g] - st), 64'(nc * per + 1));
            if (nc > 0) begin
                chk("first_av", 64'(acy[g][ab] - st), 64'(1));
                chk("last_cyc", 64'(last_cyc[g] - st), 64'(nc * per));
            end
        end
        rmode[g] = 0;
        arand[g] = 1'b0;
        err_en[g] = 1'b0;
    endtask

    vec_t tab [10];
    vec_t rv;

    initial begin
        //          g  n  ew es rm ar pt db  wd rq er
        tab[0] = '{0, 4, -1, 0, 0, 0, 0, 0,  4, 4, 0};
        tab[1] = '{1, 2, -1, 0, 0, 0, 1, 0,  2, 4, 0};
        tab[2] = '{0, 5,  2, 0, 0, 0, 0, 0,  2, 3, 1};
        tab[3] = '{0, 63, -1, 0, 0, 0, 2, 0, 50, 50, 0};
        tab[4] = '{0, 0, -1, 0, 0, 0, 2, 0,  0, 0, 0};
        tab[5] = '{1, 3,  1, 1, 0, 0, 2, 0,  1, 4, 1};
        tab[6] = '{1, 50, -1, 0, 1, 1, 2, 0, 50, 100, 0};
        tab[7] = '{0, 3, -1, 0, 0, 0, 0, 1,  3, 3, 0};
        tab[8] = '{1, 1, -1, 0, 1, 1, 0, 0,  1, 2, 0};
        tab[9] = '{0, 2,  0, 0, 1, 1, 2, 0,  0, 1, 1};

        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; num[g] = '0;
            rmode[g] = 0; arand[g] = 1'b0;
            rdy_man[g] = 1'b0; err_en[g] = 1'b0;
            err_addr[g] = '0;
            an[g] = 0; dn[g] = 0; done_cnt[g] = 0;
            done_cyc[g] = 0; last_cyc[g] = 0;
        end
        @(negedge clk);
        repeat (3) step();
        for (int g = 0; g < 2; g++) begin
            chk("rst_busy", 64'(busy[g]), 64'(0));
            chk("rst_done", 64'(done[g]), 64'(0));
            chk("rst_err", 64'(err[g]), 64'(0));
            chk("rst_stream", 64'({dvo[g], dlo[g], ddo[g]}), 64'(0));
            chk("rst_tl", 64'(tlo[g]), 64'(0));
        end
        rst_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 10; i++) run(tab[i]);

        // Consumer stall in OUT: word held, no new request.
        begin
            int t, db, d0;
            fill(0, 0);
            rmode[0] = 2; rdy_man[0] = 1'b0;
            d0 = done_cnt[0]; db = dn[0];
            start[0] = 1'b1; num[0] = 6'd2;
            step();
            start[0] = 1'b0;
            t = 0;
            while (!dvo[0] && t < 50) begin step(); t++; end
            chk("bp_valid0", 64'(dvo[0]), 64'(1));
            repeat (5) begin
                step();
                chk("bp_valid", 64'(dvo[0]), 64'(1));
                chk("bp_data", 64'(ddo[0]), 64'(32'hA500_0000));
                chk("bp_last", 64'(dlo[0]), 64'(0));
                chk("bp_noreq", 64'(tlo[0].a_valid), 64'(0));
            end
            rdy_man[0] = 1'b1;
            t = 0;
            while (done_cnt[0] == d0 && t < 200) begin step(); t++; end
            repeat (3) step();
            chk("bp_words", 64'(dn[0] - db), 64'(2));
            chk("bp_w1", 64'(dq[0][db + 1]), 64'(32'hA500_0001));
            chk("bp_l1", 64'(lq[0][db + 1]), 64'(1));
            rmode[0] = 0;
        end

        // Reset while a response is awaited, then a clean fetch.
        begin
            int t;
            fill(0, 0);
            start[0] = 1'b1; num[0] = 6'd4;
            step();
            start[0] = 1'b0;
            t = 0;
            while (!tlo[0].d_ready && t < 50) begin step(); t++; end
            chk("rsp0_reached", 64'(tlo[0].d_ready), 64'(1));
            rst_n = 1'b0;
            #1;
            chk("mid_rst_busy", 64'(busy[0]), 64'(0));
            chk("mid_rst_stream",
                64'({dvo[0], dlo[0], ddo[0]}), 64'(0));
            chk("mid_rst_tl", 64'(tlo[0]), 64'(0));
            chk("mid_rst_flags", 64'({done[0], err[0]}), 64'(0));
            repeat (2) step();
            rst_n = 1'b1;
            repeat (2) step();
            run(tab[0]);
        end

        for (int i = 0; i < 12; i++) begin
            rv.g    = int'($urandom_range(0, 1));
            rv.n    = int'($urandom_range(0, 63));
            rv.errw = ($urandom_range(0, 3) == 0) ?
                      int'($urandom_range(0, 10)) : -1;
            rv.esh  = (rv.g == 1) ? int'($urandom_range(0, 1)) : 0;
            rv.rm   = int'($urandom_range(0, 1));
            rv.arnd = int'($urandom_range(0, 1));
            rv.pat  = 2;
            rv.dbl  = 0;
            rv.exp_words = -1;
            rv.exp_reqs  = -1;
            rv.exp_err   = -1;
            run(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
